// File: rtl/ball_physics_engine.sv
// Per-frame ball physics for one board of the two-board pong game: wall bounce,
// paddle hit with spin, miss detection and ball handoff to/from the other board.
module ball_physics_engine #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int BALL_SIZE = 10,
  parameter int POS_W     = 10,
  parameter int VEL_W     = 5,
  parameter int PADDLE_X  = 16,
  parameter int PADDLE_W  = 8,
  parameter int PADDLE_H  = 64,
  parameter int MAX_VY    = 8,
  parameter int SERVE_X   = 100,
  parameter int SERVE_Y   = 235,
  parameter int SERVE_VX  = 3,
  parameter int SERVE_VY  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             serve,
  input  logic [POS_W-1:0] paddle_top,
  input  logic             ball_in_valid,
  output logic             ball_in_ready,
  input  logic [POS_W-1:0] ball_in_y,
  input  logic [VEL_W-2:0] ball_in_vx,
  input  logic [VEL_W-1:0] ball_in_vy,
  output logic             ball_out_valid,
  input  logic             ball_out_ready,
  output logic [POS_W-1:0] ball_out_y,
  output logic [VEL_W-2:0] ball_out_vx,
  output logic [VEL_W-1:0] ball_out_vy,
  output logic [POS_W-1:0] ball_left,
  output logic [POS_W-1:0] ball_top,
  output logic             ball_visible,
  output logic             miss_pulse,
  output logic [1:0]       dbg_state
);

  localparam int NW = POS_W + 2;

  typedef logic signed [NW-1:0]  npos_t;
  typedef logic signed [VEL_W-1:0] vel_t;
  typedef logic signed [VEL_W:0]   velx_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PLAY    = 2'd1,
    S_HANDOFF = 2'd2,
    S_MISS    = 2'd3
  } state_t;

  localparam npos_t LEFT_MAX = npos_t'(SCREEN_W - BALL_SIZE);
  localparam npos_t TOP_MAX  = npos_t'(SCREEN_H - BALL_SIZE);
  localparam npos_t FACE     = npos_t'(PADDLE_X + PADDLE_W);
  localparam npos_t BALL_SZ  = npos_t'(BALL_SIZE);
  localparam npos_t HALF     = npos_t'(BALL_SIZE / 2);
  localparam npos_t PAD_H    = npos_t'(PADDLE_H);
  localparam npos_t Q1       = npos_t'(PADDLE_H / 4);
  localparam npos_t Q3       = npos_t'((3 * PADDLE_H) / 4);
  localparam velx_t VY_LIM   = velx_t'(MAX_VY);

  localparam logic [POS_W-1:0] LEFT_IN   = POS_W'(SCREEN_W - BALL_SIZE);
  localparam logic [POS_W-1:0] TOP_LIM   = POS_W'(SCREEN_H - BALL_SIZE);
  localparam logic [POS_W-1:0] FACE_P    = POS_W'(PADDLE_X + PADDLE_W);
  localparam logic [POS_W-1:0] SERVE_X_P = POS_W'(SERVE_X);
  localparam logic [POS_W-1:0] SERVE_Y_P = POS_W'(SERVE_Y);
  localparam vel_t             SERVE_VXV = vel_t'(SERVE_VX);
  localparam vel_t             SERVE_VYV = vel_t'(SERVE_VY);

  state_t           state_q;
  logic [POS_W-1:0] left_q, top_q;
  vel_t             vx_q, vy_q;
  logic [POS_W-1:0] out_y_q;
  logic [VEL_W-2:0] out_vx_q;
  vel_t             out_vy_q;
  logic             out_valid_q, miss_q, visible_q, in_ready_q;

  function automatic vel_t sat_vy(input velx_t v);
    if (v > VY_LIM)       return vel_t'(VY_LIM);
    else if (v < -VY_LIM) return vel_t'(-VY_LIM);
    else                  return vel_t'(v);
  endfunction

  npos_t            nl, nt, pt, off;
  logic [POS_W-1:0] top_w;
  velx_t            vy_w, vy_spin;
  vel_t             vy_next;
  logic             miss_c, exit_c, hit_c;
  logic [POS_W-1:0] in_top;
  logic [VEL_W-2:0] in_mag;
  vel_t             in_vx_v, in_vy_v;

  // Next-frame candidate position, computed wide and signed so that
  // off-screen results are visible before they are committed.
  always_comb begin
    nl      = $signed({2'b00, left_q}) + npos_t'(vx_q);
    nt      = $signed({2'b00, top_q}) + npos_t'(vy_q);
    pt      = $signed({2'b00, paddle_top});
    off     = nt + HALF - pt;
    top_w   = nt[POS_W-1:0];
    vy_w    = velx_t'(vy_q);
    if (nt[NW-1]) begin
      top_w = '0;
      vy_w  = -velx_t'(vy_q);
    end else if (nt > TOP_MAX) begin
      top_w = TOP_LIM;
      vy_w  = -velx_t'(vy_q);
    end
    miss_c  = nl[NW-1];
    exit_c  = !vx_q[VEL_W-1] && (vx_q != '0) && (nl > LEFT_MAX);
    hit_c   = vx_q[VEL_W-1] && ($signed({2'b00, left_q}) > FACE) && (nl <= FACE)
              && (nt + BALL_SZ > pt) && (nt < pt + PAD_H);
    vy_spin = vy_w;
    if (hit_c) begin
      if (off < Q1)       vy_spin = vy_w - velx_t'(1);
      else if (off >= Q3) vy_spin = vy_w + velx_t'(1);
    end
    vy_next = sat_vy(vy_spin);
  end

  always_comb begin
    in_top  = (ball_in_y > TOP_LIM) ? TOP_LIM : ball_in_y;
    in_mag  = (ball_in_vx == '0) ? (VEL_W-1)'(1) : ball_in_vx;
    in_vx_v = -vel_t'({1'b0, in_mag});
    in_vy_v = sat_vy(velx_t'($signed(ball_in_vy)));
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // ball_out_valid, once raised, stays high with ball_out_* held until taken;
  // ball_in_ready is high exactly while idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      left_q      <= SERVE_X_P;
      top_q       <= SERVE_Y_P;
      vx_q        <= '0;
      vy_q        <= '0;
      out_y_q     <= '0;
      out_vx_q    <= '0;
      out_vy_q    <= '0;
      out_valid_q <= 1'b0;
      miss_q      <= 1'b0;
      visible_q   <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ball_in_valid) begin
            left_q     <= LEFT_IN;
            top_q      <= in_top;
            vx_q       <= in_vx_v;
            vy_q       <= in_vy_v;
            state_q    <= S_PLAY;
            in_ready_q <= 1'b0;
            visible_q  <= 1'b1;
          end else if (serve) begin
            left_q     <= SERVE_X_P;
            top_q      <= SERVE_Y_P;
            vx_q       <= SERVE_VXV;
            vy_q       <= SERVE_VYV;
            state_q    <= S_PLAY;
            in_ready_q <= 1'b0;
            visible_q  <= 1'b1;
          end
        end
        S_PLAY: begin
          if (frame_tick) begin
            if (miss_c) begin
              state_q   <= S_MISS;
              visible_q <= 1'b0;
              miss_q    <= 1'b1;
            end else begin
              top_q <= top_w;
              vy_q  <= vy_next;
              if (exit_c) begin
                state_q     <= S_HANDOFF;
                visible_q   <= 1'b0;
                out_valid_q <= 1'b1;
                out_y_q     <= top_w;
                out_vx_q    <= vx_q[VEL_W-2:0];
                out_vy_q    <= vy_next;
              end else if (hit_c) begin
                left_q <= FACE_P;
                vx_q   <= -vx_q;
              end else begin
                left_q <= nl[POS_W-1:0];
              end
            end
          end
        end
        S_HANDOFF: begin
          if (ball_out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        S_MISS: begin
          miss_q     <= 1'b0;
          state_q    <= S_IDLE;
          in_ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ball_in_ready  = in_ready_q;
  assign ball_out_valid = out_valid_q;
  assign ball_out_y     = out_y_q;
  assign ball_out_vx    = out_vx_q;
  assign ball_out_vy    = out_vy_q;
  assign ball_left      = left_q;
  assign ball_top       = top_q;
  assign ball_visible   = visible_q;
  assign miss_pulse     = miss_q;
  assign dbg_state      = state_q;

endmodule
